gcd_controller: RTL

//  Moore FSM that sequences gcd_datapath: loads operands, subtracts repeatedly on

---
 rtl/gcd_pkg.sv | 69 ++++++
 rtl/gcd_watchdog.sv | 27 ++
 rtl/gcd_controller.sv | 87 ++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the GCD controller: state encoding, control-word payload and defaults.
package gcd_pkg;

    localparam int unsigned STATE_W          = 3;
    localparam int unsigned MAX_ITER_DEFAULT = 15;
    localparam int unsigned ITER_W_DEFAULT   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CMP  = 3'd2,
        S_SUBX = 3'd3,
        S_SUBY = 3'd4,
        S_GLD  = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    typedef struct packed {
        logic xmsel;
        logic ymsel;
        logic xld;
        logic yld;
        logic gld;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    // Moore output decode: control word presented while in state s
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_LOAD: begin
                c.xmsel = 1'b1;
                c.ymsel = 1'b1;
                c.xld   = 1'b1;
                c.yld   = 1'b1;
                c.busy  = 1'b1;
            end
            S_CMP:  c.busy = 1'b1;
            S_SUBX: begin
                c.xld  = 1'b1;
                c.busy = 1'b1;
            end
            S_SUBY: begin
                c.yld  = 1'b1;
                c.busy = 1'b1;
            end
            S_GLD: begin
                c.gld  = 1'b1;
                c.busy = 1'b1;
            end
            S_DONE: begin
                c.done = 1'b1;
                c.busy = 1'b1;
            end
            S_ERR: begin
                c.done = 1'b1;
                c.err  = 1'b1;
                c.busy = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gcd_watchdog.sv
// Subtract-step counter with limit compare; aborts non-converging runs (zero operand).
module gcd_watchdog #(
    parameter int unsigned MAX_ITER = 15,
    parameter int unsigned ITER_W   = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic inc,
    output logic at_limit_c
);

    logic [ITER_W-1:0] count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ITER_W'(1);
        end
    end

    assign at_limit_c = (count == ITER_W'(MAX_ITER));

endmodule

// File: rtl/gcd_controller.sv
// Moore FSM sequencing gcd_datapath: load, subtract until equal, capture gcd, done pulse.
// Optional watchdog abort enabled by defining GCD_WDOG_EN.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int unsigned MAX_ITER = MAX_ITER_DEFAULT,
    parameter int unsigned ITER_W   = ITER_W_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic eqflg,
    input  logic itflg,
    output logic xmsel,
    output logic ymsel,
    output logic xld,
    output logic yld,
    output logic gld,
    output logic busy,
    output logic done,
    output logic err
);

    if (MAX_ITER >= (1 << ITER_W)) begin : g_bad_cfg
        $error("gcd_controller: ITER_W too narrow for MAX_ITER");
    end

    state_t state, state_next;
    ctrl_t  ctrl_q;
    logic   wdog_limit_c;

`ifdef GCD_WDOG_EN
    gcd_watchdog #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) u_watchdog (
        .clk        (clk),
        .clr        (clr),
        .clear      (state == S_LOAD),
        .inc        ((state == S_SUBX) || (state == S_SUBY)),
        .at_limit_c (wdog_limit_c)
    );
`else
    assign wdog_limit_c = 1'b0;
`endif

    // Outputs are registered from the next-state decode so they track the state register exactly
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= S_IDLE;
            ctrl_q <= '0;
        end else begin
            state  <= state_next;
            ctrl_q <= decode(state_next);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_CMP;
            S_CMP: begin
                if (eqflg)             state_next = S_GLD;
                else if (wdog_limit_c) state_next = S_ERR;
                else if (itflg)        state_next = S_SUBY;
                else                   state_next = S_SUBX;
            end
            S_SUBX:  state_next = S_CMP;
            S_SUBY:  state_next = S_CMP;
            S_GLD:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign xmsel = ctrl_q.xmsel;
    assign ymsel = ctrl_q.ymsel;
    assign xld   = ctrl_q.xld;
    assign yld   = ctrl_q.yld;
    assign gld   = ctrl_q.gld;
    assign busy  = ctrl_q.busy;
    assign done  = ctrl_q.done;
    assign err   = ctrl_q.err;

endmodule
